// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//
// Load-use hazard detector for the decode stage. It supports data memories
// whose load data becomes forwardable LOAD_LAT cycles after the load leaves
// ID/EX. A shift-register scoreboard holds one {valid, rd} entry per
// in-flight load. While any used, non-x0 source of the IF/ID instruction
// depends on such a load, or on a load still sitting in ID/EX, the block:
//   - freezes the PC and IF/ID, and
//   - bubbles ID/EX.
//
// Parameters:
//   REG_ADDR_W      register address width
//   LOAD_LAT        extra load latency (0..4); 0 removes the scoreboard
//
// Ports:
//   clk             clock, all state on rising edge
//   arst_n          asynchronous active-low reset
//   mem_read_id_exe ID/EX instruction is a load
//   rd_id_exe       ID/EX destination register
//   rs1_if_id       IF/ID source 1
//   rs2_if_id       IF/ID source 2
//   rs1_used        IF/ID instruction reads rs1
//   rs2_used        IF/ID instruction reads rs2
//   flush           IF/ID instruction squashed this cycle (suppresses stall)
//   pipe_hold       whole pipeline frozen; scoreboard holds
//   pc_write        1 = PC may update
//   if_id_write     1 = IF/ID may update
//   stall_control   0 = bubble ID/EX control, 1 = normal
//   busy            any scoreboard entry valid
//   stall_cycles    (only with HAZARD_PERF_CNT_EN) saturating count of
//                   un-held hazard cycles
//
// Optional feature: define HAZARD_PERF_CNT_EN to add the stall_cycles output.

module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  mem_read_id_exe,
  input  logic [REG_ADDR_W-1:0] rd_id_exe,
  input  logic [REG_ADDR_W-1:0] rs1_if_id,
  input  logic [REG_ADDR_W-1:0] rs2_if_id,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  flush,
  input  logic                  pipe_hold,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  stall_control,
  output logic                  busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  // A source can only create a hazard when it is actually read and is not x0.
  logic rs1_active;
  logic rs2_active;
  logic rs1_ex_hit;
  logic rs2_ex_hit;
  logic rs1_sb_hit;
  logic rs2_sb_hit;
  logic hazard;

  assign rs1_active = rs1_used && (rs1_if_id != '0);
  assign rs2_active = rs2_used && (rs2_if_id != '0);

  // Term (a): the load is still in ID/EX, so its data is not available yet.
  assign rs1_ex_hit = mem_read_id_exe && (rd_id_exe == rs1_if_id);
  assign rs2_ex_hit = mem_read_id_exe && (rd_id_exe == rs2_if_id);

  generate
    if (LOAD_LAT > 0) begin : g_sb
      logic [LOAD_LAT-1:0]   valid_reg;
      logic [REG_ADDR_W-1:0] rd_reg [LOAD_LAT];
      logic [LOAD_LAT-1:0]   rs1_hit_vec;
      logic [LOAD_LAT-1:0]   rs2_hit_vec;

      // The load in ID/EX always moves on (only the younger instruction is
      // bubbled), so the scoreboard shifts even while stalling. Only a
      // pipeline-wide hold freezes it.
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          for (int k = 0; k < LOAD_LAT; k++) begin
            valid_reg[k] <= 1'b0;
            rd_reg[k]    <= '0;
          end
        end else if (!pipe_hold) begin
          valid_reg[0] <= mem_read_id_exe && (rd_id_exe != '0);
          rd_reg[0]    <= rd_id_exe;
          for (int k = 1; k < LOAD_LAT; k++) begin
            valid_reg[k] <= valid_reg[k-1];
            rd_reg[k]    <= rd_reg[k-1];
          end
        end
      end

      for (genvar gi = 0; gi < LOAD_LAT; gi++) begin : g_match
        assign rs1_hit_vec[gi] = valid_reg[gi] && (rd_reg[gi] == rs1_if_id);
        assign rs2_hit_vec[gi] = valid_reg[gi] && (rd_reg[gi] == rs2_if_id);
      end

      assign rs1_sb_hit = |rs1_hit_vec;
      assign rs2_sb_hit = |rs2_hit_vec;
      assign busy       = |valid_reg;
    end else begin : g_no_sb
      // Data is forwardable as soon as the load leaves ID/EX.
      assign rs1_sb_hit = 1'b0;
      assign rs2_sb_hit = 1'b0;
      assign busy       = 1'b0;
    end
  endgenerate

  assign hazard = ((rs1_active && (rs1_ex_hit || rs1_sb_hit)) ||
                   (rs2_active && (rs2_ex_hit || rs2_sb_hit))) && !flush;

  assign pc_write      = !hazard;
  assign if_id_write   = !hazard;
  assign stall_control = !hazard;

`ifdef HAZARD_PERF_CNT_EN
  // Held cycles are not counted, so the count reflects hazard-only stalls.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cycles <= '0;
    end else if (hazard && !pipe_hold && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Testbench for hazard_scoreboard_unit. It drives one LOAD_LAT=1 instance and
// one LOAD_LAT=0 instance with shared inputs, one vector per clock cycle.
// Each vector carries hand-computed expectations. These are queued, and a
// monitor on the falling edge pops them and compares them against the
// outputs.

module tb_hazard_scoreboard_unit;

  logic       clk;
  logic       arst_n;
  logic       mem_read_id_exe;
  logic [4:0] rd_id_exe;
  logic [4:0] rs1_if_id;
  logic [4:0] rs2_if_id;
  logic       rs1_used;
  logic       rs2_used;
  logic       flush;
  logic       pipe_hold;

  logic pc_write;
  logic if_id_write;
  logic stall_control;
  logic busy;
  logic pc_write0;
  logic if_id_write0;
  logic stall_control0;
  logic busy0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] stall_cycles0;
`endif

  hazard_scoreboard_unit #(.REG_ADDR_W(5), .LOAD_LAT(1)) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .mem_read_id_exe (mem_read_id_exe),
    .rd_id_exe       (rd_id_exe),
    .rs1_if_id       (rs1_if_id),
    .rs2_if_id       (rs2_if_id),
    .rs1_used        (rs1_used),
    .rs2_used        (rs2_used),
    .flush           (flush),
    .pipe_hold       (pipe_hold),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .stall_control   (stall_control),
    .busy            (busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  hazard_scoreboard_unit #(.REG_ADDR_W(5), .LOAD_LAT(0)) dut_lat0 (
    .clk             (clk),
    .arst_n          (arst_n),
    .mem_read_id_exe (mem_read_id_exe),
    .rd_id_exe       (rd_id_exe),
    .rs1_if_id       (rs1_if_id),
    .rs2_if_id       (rs2_if_id),
    .rs1_used        (rs1_used),
    .rs2_used        (rs2_used),
    .flush           (flush),
    .pipe_hold       (pipe_hold),
    .pc_write        (pc_write0),
    .if_id_write     (if_id_write0),
    .stall_control   (stall_control0),
    .busy            (busy0)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    ok;
    bit    busy;
    bit    ok0;
    int    cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input string sig, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s %s: got %0d, expected %0d", name, sig, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so each cycle presents a response.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "pc_write", int'(pc_write), int'(e.ok));
      chk(e.name, "if_id_write", int'(if_id_write), int'(e.ok));
      chk(e.name, "stall_control", int'(stall_control), int'(e.ok));
      chk(e.name, "busy", int'(busy), int'(e.busy));
      chk(e.name, "lat0_pc_write", int'(pc_write0), int'(e.ok0));
      chk(e.name, "lat0_stall_control", int'(stall_control0), int'(e.ok0));
      chk(e.name, "lat0_busy", int'(busy0), 0);
`ifdef HAZARD_PERF_CNT_EN
      chk(e.name, "stall_cycles", int'(stall_cycles), e.cnt);
`endif
      $display("cycle %-14s pc_write=%0d busy=%0d lat0_pc_write=%0d", e.name,
               pc_write, busy, pc_write0);
    end
  end

  // One vector per cycle. Inputs change just after the rising edge, so an
  // arst_n drop lands between edges.
  task automatic step(input string name, input bit rstn, input bit mr,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input bit u1, input bit u2,
                      input bit fl, input bit ph, input bit ok,
                      input bit bsy, input bit ok0, input int cnt);
    exp_t e;
    @(posedge clk);
    #1;
    arst_n          = rstn;
    mem_read_id_exe = mr;
    rd_id_exe       = rd;
    rs1_if_id       = rs1;
    rs2_if_id       = rs2;
    rs1_used        = u1;
    rs2_used        = u2;
    flush           = fl;
    pipe_hold       = ph;
    e.name = name;
    e.ok   = ok;
    e.busy = bsy;
    e.ok0  = ok0;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    arst_n          = 1'b0;
    mem_read_id_exe = 1'b0;
    rd_id_exe       = '0;
    rs1_if_id       = '0;
    rs2_if_id       = '0;
    rs1_used        = 1'b0;
    rs2_used        = 1'b0;
    flush           = 1'b0;
    pipe_hold       = 1'b0;

    //   name            rstn mr rd  rs1 rs2 u1 u2 fl ph  ok busy ok0 cnt
    step("reset",          0, 0, 0,  0,  0,  0, 0, 0, 0,  1, 0,   1,  0);
    step("idle",           1, 0, 0,  0,  0,  0, 0, 0, 0,  1, 0,   1,  0);
    // load rd=5 directly followed by a consumer: 2-cycle stall
    step("ld5_use",        1, 1, 5,  5,  0,  1, 0, 0, 0,  0, 0,   0,  0);
    step("ld5_stall2",     1, 0, 0,  5,  0,  1, 0, 0, 0,  0, 1,   1,  1);
    step("ld5_go",         1, 0, 0,  5,  0,  1, 0, 0, 0,  1, 0,   1,  2);
    // x0 destination/source and unused operand never stall
    step("ld_x0",          1, 1, 0,  0,  0,  1, 0, 0, 0,  1, 0,   1,  2);
    step("x0_use",         1, 0, 0,  0,  0,  1, 0, 0, 0,  1, 0,   1,  2);
    step("ld6_unused",     1, 1, 6,  0,  6,  0, 0, 0, 0,  1, 0,   1,  2);
    step("rs2_unused",     1, 0, 0,  0,  6,  0, 0, 0, 0,  1, 1,   1,  2);
    // flush suppresses the first stall cycle only
    step("ld9_flush",      1, 1, 9,  0,  9,  0, 1, 1, 0,  1, 0,   1,  2);
    step("ld9_stall",      1, 0, 0,  0,  9,  0, 1, 0, 0,  0, 1,   1,  2);
    step("ld9_go",         1, 0, 0,  0,  9,  0, 1, 0, 0,  1, 0,   1,  3);
    // pipe_hold for 3 cycles after the first edge: 5-cycle stall, count +2
    step("hold_ld5",       1, 1, 5,  5,  0,  1, 0, 0, 0,  0, 0,   0,  3);
    step("hold_1",         1, 0, 0,  5,  0,  1, 0, 0, 1,  0, 1,   1,  4);
    step("hold_2",         1, 0, 0,  5,  0,  1, 0, 0, 1,  0, 1,   1,  4);
    step("hold_3",         1, 0, 0,  5,  0,  1, 0, 0, 1,  0, 1,   1,  4);
    step("hold_end",       1, 0, 0,  5,  0,  1, 0, 0, 0,  0, 1,   1,  4);
    step("hold_go",        1, 0, 0,  5,  0,  1, 0, 0, 0,  1, 0,   1,  5);
    // consumer one cycle after the load: 1-cycle stall
    step("ld8_gap",        1, 1, 8,  1,  0,  1, 0, 0, 0,  1, 0,   1,  5);
    step("late_use",       1, 0, 0,  8,  0,  1, 0, 0, 0,  0, 1,   1,  5);
    step("late_go",        1, 0, 0,  8,  0,  1, 0, 0, 0,  1, 0,   1,  6);
    // back-to-back loads each tracked in their own cycle
    step("b2b_ld10",       1, 1, 10, 11, 0,  1, 0, 0, 0,  1, 0,   1,  6);
    step("b2b_ld11",       1, 1, 11, 10, 0,  1, 0, 0, 0,  0, 1,   1,  6);
    step("b2b_use11",      1, 0, 0,  10, 11, 1, 1, 0, 0,  0, 1,   1,  7);
    step("b2b_go",         1, 0, 0,  10, 11, 1, 1, 0, 0,  1, 0,   1,  8);
    // reset between edges drops a tracked load immediately
    step("rst_ld7",        1, 1, 7,  7,  0,  1, 0, 0, 0,  0, 0,   0,  8);
    step("rst_held",       1, 0, 0,  7,  0,  1, 0, 0, 1,  0, 1,   1,  9);
    step("rst_mid",        0, 0, 0,  7,  0,  1, 0, 0, 0,  1, 0,   1,  0);
    step("rst_rel",        1, 0, 0,  7,  0,  1, 0, 0, 0,  1, 0,   1,  0);
    // term (a) still applies while reset is held
    step("rst_terma",      0, 1, 3,  3,  0,  1, 0, 0, 0,  0, 0,   0,  0);
    // load rd=3 then consumer: LOAD_LAT=0 instance stalls a single cycle
    step("ld3_use",        1, 1, 3,  3,  0,  1, 0, 0, 0,  0, 0,   0,  0);
    step("ld3_next",       1, 0, 0,  3,  0,  1, 0, 0, 0,  0, 1,   1,  1);
    step("ld3_go",         1, 0, 0,  3,  0,  1, 0, 0, 0,  1, 0,   1,  2);

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
